// File: rtl/alu_result_buffer.sv
// -----------------------------------------------------------------------------
// alu_result_buffer
//
// Two-entry in-order skid buffer between the ALU and register writeback.
// Completed ALU results are queued here until writeback accepts them, and
// the buffered results are offered to the operand bypass network so that
// dependent instructions do not have to wait for writeback.
//
// Handshake: a transfer happens on a rising edge only when valid and ready
// are both high in that cycle. in_ready depends only on registered occupancy
// and flush_i, never on in_valid. A producer holding valid keeps its payload
// stable until the transfer.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush_i                    drop all buffered and incoming entries
//   in_valid / in_ready        upstream handshake
//   in_result, in_rd, in_we,   ALU result, destination index, write enable,
//   in_pc                      PC of the producing instruction
//   out_valid / out_ready      writeback handshake for the head entry
//   out_result, out_rd,        head entry fields (zero when empty)
//   out_we, out_pc
//   fwd_rs1, fwd_rs2           operand indices looked up for bypass
//   fwd_rs1_hit/_data,         bypass hit flag and youngest matching result
//   fwd_rs2_hit/_data
//   count                      number of valid entries (0..2)
// -----------------------------------------------------------------------------
module alu_result_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_result,
    input  logic [4:0]      in_rd,
    input  logic            in_we,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_we,
    output logic [XLEN-1:0] out_pc,
    input  logic [4:0]      fwd_rs1,
    input  logic [4:0]      fwd_rs2,
    output logic            fwd_rs1_hit,
    output logic [XLEN-1:0] fwd_rs1_data,
    output logic            fwd_rs2_hit,
    output logic [XLEN-1:0] fwd_rs2_data,
    output logic [1:0]      count
);

    localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

    // Entry storage
    logic [XLEN-1:0] r_result [2];
    logic [4:0]      r_rd     [2];
    logic            r_we     [2];
    logic [XLEN-1:0] r_pc     [2];

    logic            r_rptr;
    logic            r_wptr;
    logic [1:0]      r_count;

    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic [1:0]      w_ent_valid;

    assign w_empty   = (r_count == 2'd0);
    assign in_ready  = (r_count != FULL_COUNT) & ~flush_i;
    assign out_valid = ~w_empty & ~flush_i;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign count     = r_count;

    // Head entry fields, forced to zero while empty
    assign out_result = w_empty ? '0    : r_result[r_rptr];
    assign out_rd     = w_empty ? 5'd0  : r_rd[r_rptr];
    assign out_we     = w_empty ? 1'b0  : r_we[r_rptr];
    assign out_pc     = w_empty ? '0    : r_pc[r_rptr];

    // The youngest entry always sits just behind the write pointer (~r_wptr);
    // the other slot only holds live data when the buffer is full.
    always_comb begin
        w_ent_valid = 2'b00;
        if (!w_empty) begin
            w_ent_valid[~r_wptr] = 1'b1;
        end
        if (r_count == FULL_COUNT) begin
            w_ent_valid[r_wptr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rptr  <= 1'b0;
            r_wptr  <= 1'b0;
            r_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_result[i] <= '0;
                r_rd[i]     <= 5'd0;
                r_we[i]     <= 1'b0;
                r_pc[i]     <= '0;
            end
        end else if (flush_i) begin
            r_rptr  <= 1'b0;
            r_wptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_result[r_wptr] <= in_result;
                r_rd[r_wptr]     <= in_rd;
                r_we[r_wptr]     <= in_we;
                r_pc[r_wptr]     <= in_pc;
                r_wptr           <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Bypass lookup: scan oldest (r_wptr) then youngest (~r_wptr) so that a
    // younger match overrides an older one. Register 0 never forwards.
    logic w_idx1;
    logic w_idx2;

    always_comb begin
        fwd_rs1_hit  = 1'b0;
        fwd_rs1_data = '0;
        w_idx1       = r_wptr;
        for (int k = 0; k < 2; k++) begin
            w_idx1 = (k == 0) ? r_wptr : ~r_wptr;
            if (!flush_i && w_ent_valid[w_idx1] && r_we[w_idx1] &&
                (fwd_rs1 != 5'd0) && (r_rd[w_idx1] == fwd_rs1)) begin
                fwd_rs1_hit  = 1'b1;
                fwd_rs1_data = r_result[w_idx1];
            end
        end
    end

    always_comb begin
        fwd_rs2_hit  = 1'b0;
        fwd_rs2_data = '0;
        w_idx2       = r_wptr;
        for (int k = 0; k < 2; k++) begin
            w_idx2 = (k == 0) ? r_wptr : ~r_wptr;
            if (!flush_i && w_ent_valid[w_idx2] && r_we[w_idx2] &&
                (fwd_rs2 != 5'd0) && (r_rd[w_idx2] == fwd_rs2)) begin
                fwd_rs2_hit  = 1'b1;
                fwd_rs2_data = r_result[w_idx2];
            end
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// -----------------------------------------------------------------------------
// tb_alu_result_buffer
//
// Directed scenarios followed by random traffic. The reference model is a
// plain queue of entries: front is the head, back is the youngest; bypass is
// a backward search of that queue.
// -----------------------------------------------------------------------------
module tb_alu_result_buffer;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            flush_i;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_result;
    logic [4:0]      in_rd;
    logic            in_we;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [4:0]      out_rd;
    logic            out_we;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      fwd_rs1;
    logic [4:0]      fwd_rs2;
    logic            fwd_rs1_hit;
    logic [XLEN-1:0] fwd_rs1_data;
    logic            fwd_rs2_hit;
    logic [XLEN-1:0] fwd_rs2_data;
    logic [1:0]      count;

    alu_result_buffer #(.XLEN(XLEN), .DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_rd        (in_rd),
        .in_we        (in_we),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_rd       (out_rd),
        .out_we       (out_we),
        .out_pc       (out_pc),
        .fwd_rs1      (fwd_rs1),
        .fwd_rs2      (fwd_rs2),
        .fwd_rs1_hit  (fwd_rs1_hit),
        .fwd_rs1_data (fwd_rs1_data),
        .fwd_rs2_hit  (fwd_rs2_hit),
        .fwd_rs2_data (fwd_rs2_data),
        .count        (count)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [XLEN-1:0] res;
        logic [4:0]      rd;
        logic            we;
        logic [XLEN-1:0] pc;
    } ent_t;

    ent_t exp_q[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fwd_model(input logic [4:0] rs, output logic hit, output logic [XLEN-1:0] data);
        hit  = 1'b0;
        data = '0;
        if (!flush_i && rs != 5'd0) begin
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].we && exp_q[i].rd == rs) begin
                    hit  = 1'b1;
                    data = exp_q[i].res;
                    break;
                end
            end
        end
    endtask

    task automatic check_outputs();
        int              n;
        logic            h;
        logic [XLEN-1:0] d;
        n = exp_q.size();
        chk("count", 64'(count), 64'(n));
        chk("in_ready", 64'(in_ready), 64'(n < 2 && !flush_i));
        chk("out_valid", 64'(out_valid), 64'(n > 0 && !flush_i));
        if (n > 0) begin
            chk("out_result", 64'(out_result), 64'(exp_q[0].res));
            chk("out_rd", 64'(out_rd), 64'(exp_q[0].rd));
            chk("out_we", 64'(out_we), 64'(exp_q[0].we));
            chk("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
        end else begin
            chk("out_result_empty", 64'(out_result), 64'd0);
            chk("out_rd_empty", 64'(out_rd), 64'd0);
            chk("out_we_empty", 64'(out_we), 64'd0);
            chk("out_pc_empty", 64'(out_pc), 64'd0);
        end
        fwd_model(fwd_rs1, h, d);
        chk("fwd_rs1_hit", 64'(fwd_rs1_hit), 64'(h));
        chk("fwd_rs1_data", 64'(fwd_rs1_data), 64'(d));
        fwd_model(fwd_rs2, h, d);
        chk("fwd_rs2_hit", 64'(fwd_rs2_hit), 64'(h));
        chk("fwd_rs2_data", 64'(fwd_rs2_data), 64'(d));
    endtask

    // ---------------- driver tasks ----------------
    // Called right after a falling edge.
    task automatic set_in(input logic v, input logic [XLEN-1:0] res, input logic [4:0] rd,
                          input logic we, input logic ordy);
        in_valid  = v;
        in_result = res;
        in_rd     = rd;
        in_we     = we;
        in_pc     = $urandom;
        out_ready = ordy;
    endtask

    // Check current outputs, advance one rising edge, update the model,
    // and return at the following falling edge.
    task automatic tick();
        logic do_push;
        logic do_pop;
        ent_t e;
        #2;
        check_outputs();
        do_push = in_valid && exp_q.size() < 2 && !flush_i;
        do_pop  = out_ready && exp_q.size() > 0 && !flush_i;
        e.res = in_result;
        e.rd  = in_rd;
        e.we  = in_we;
        e.pc  = in_pc;
        @(posedge clk);
        if (flush_i) begin
            exp_q.delete();
        end else begin
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        set_in(1'b0, '0, 5'd0, 1'b0, 1'b1);
        repeat (2) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        flush_i   = 1'b0;
        in_valid  = 1'b0;
        in_result = '0;
        in_rd     = 5'd0;
        in_we     = 1'b0;
        in_pc     = '0;
        out_ready = 1'b0;
        fwd_rs1   = 5'd0;
        fwd_rs2   = 5'd0;

        // Reset state
        #1;
        check_outputs();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single push, first edge after reset release
        set_in(1'b1, 32'h0000_0005, 5'd3, 1'b1, 1'b0);
        fwd_rs1 = 5'd3;
        tick();
        set_in(1'b0, '0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("single_out_valid", 64'(out_valid), 64'd1);
        chk("single_out_rd", 64'(out_rd), 64'd3);
        chk("single_count", 64'(count), 64'd1);
        chk("single_fwd_hit", 64'(fwd_rs1_hit), 64'd1);
        chk("single_fwd_data", 64'(fwd_rs1_data), 64'd5);
        tick();

        // Fill to two, extra push held off for three cycles
        set_in(1'b1, 32'h77, 5'd9, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 32'h99, 5'd12, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("full_count", 64'(count), 64'd2);
            chk("full_in_ready", 64'(in_ready), 64'd0);
            chk("full_head_rd", 64'(out_rd), 64'd3);
            tick();
        end
        drain();

        // Push and pop together at count 1, ten times
        set_in(1'b1, 32'h100, 5'd1, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 32'h200 + 32'(i), 5'd7, 1'b1, 1'b1);
            tick();
            #1;
            chk("pp_count", 64'(count), 64'd1);
            chk("pp_head_rd", 64'(out_rd), 64'd7);
            chk("pp_head_res", 64'(out_result), 64'(32'h200 + 32'(i)));
        end
        drain();

        // Youngest match wins; rd 0 never forwards
        fwd_rs1 = 5'd0;
        fwd_rs2 = 5'd4;
        set_in(1'b1, 32'h11, 5'd4, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 32'h22, 5'd4, 1'b1, 1'b0);
        tick();
        set_in(1'b0, '0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("young_hit", 64'(fwd_rs2_hit), 64'd1);
        chk("young_data", 64'(fwd_rs2_data), 64'h22);
        tick();
        drain();
        set_in(1'b1, 32'h33, 5'd0, 1'b1, 1'b0);
        tick();
        set_in(1'b0, '0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("rd0_hit", 64'(fwd_rs1_hit), 64'd0);
        tick();
        drain();

        // Flush while full with a pending push
        set_in(1'b1, 32'h44, 5'd5, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 32'h55, 5'd6, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 32'h66, 5'd8, 1'b1, 1'b0);
        flush_i = 1'b1;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        tick();
        flush_i = 1'b0;
        set_in(1'b0, '0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("flush_count", 64'(count), 64'd0);
        tick();

        // Asynchronous reset pulse between edges while full
        set_in(1'b1, 32'h77, 5'd10, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 32'h88, 5'd11, 1'b1, 1'b0);
        tick();
        set_in(1'b0, '0, 5'd0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        exp_q.delete();
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        set_in(1'b1, 32'hAB, 5'd5, 1'b1, 1'b0);
        tick();
        set_in(1'b0, '0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("arst_post_valid", 64'(out_valid), 64'd1);
        chk("arst_post_rd", 64'(out_rd), 64'd5);
        tick();
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            flush_i = ($urandom_range(0, 15) == 0);
            set_in(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            fwd_rs1 = 5'($urandom_range(0, 7));
            fwd_rs2 = 5'($urandom_range(0, 7));
            tick();
        end
        flush_i = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Bound on total run time
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
